// File: rtl/collision_search_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | collision_search_scheduler: clear/launch/run/halt sequencing of a searcher   |
// | array with lowest-index winner select, cycle budget and abort.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module collision_search_scheduler #(
  parameter int NUM_SEARCHERS = 32,
  parameter int IDX_W         = 5,
  parameter int TARGET_W      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_start,
  input  logic [TARGET_W-1:0]         cmd_target,
  input  logic [31:0]                 cmd_timeout,
  input  logic                        cmd_abort,
  output logic                        busy,
  output logic                        found,
  output logic                        timed_out,
  output logic [31:0]                 result,
  output logic [IDX_W-1:0]            result_index,
  output logic [31:0]                 cycles,
  output logic                        srch_clear,
  output logic                        srch_start,
  output logic [TARGET_W-1:0]         srch_target,
  input  logic [NUM_SEARCHERS-1:0]    srch_done,
  input  logic [32*NUM_SEARCHERS-1:0] srch_result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_busy, r_found, r_timed_out, r_clear, r_start;
  logic [31:0]         r_result, r_cycles, r_budget;
  logic [IDX_W-1:0]    r_index;
  logic [TARGET_W-1:0] r_target;

  logic                w_found_nxt, w_timed_out_nxt;
  logic [31:0]         w_result_nxt, w_cycles_nxt, w_budget_nxt, w_cyc_inc;
  logic [IDX_W-1:0]    w_index_nxt, w_win_idx;
  logic [TARGET_W-1:0] w_target_nxt;
  logic [31:0]         w_win_res;
  logic                w_any_done;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    w_any_done = |srch_done;
    w_win_idx  = '0;
    w_win_res  = '0;
    for (int i = NUM_SEARCHERS - 1; i >= 0; i--) begin
      if (srch_done[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_res = srch_result[32*i +: 32];
      end
    end
  end

  assign w_cyc_inc = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_found_nxt     = r_found;
    w_timed_out_nxt = r_timed_out;
    w_result_nxt    = r_result;
    w_index_nxt     = r_index;
    w_cycles_nxt    = r_cycles;
    w_budget_nxt    = r_budget;
    w_target_nxt    = r_target;
    case (r_state)
      S_IDLE: begin
        if (cmd_start) begin
          w_target_nxt = cmd_target;
          w_budget_nxt = cmd_timeout;
          w_state_nxt  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_found_nxt     = 1'b0;
        w_timed_out_nxt = 1'b0;
        w_cycles_nxt    = '0;
        w_result_nxt    = '0;
        w_index_nxt     = '0;
        w_state_nxt     = S_LAUNCH;
      end
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN: begin
        w_cycles_nxt = w_cyc_inc;
        if (w_any_done) begin
          w_found_nxt  = 1'b1;
          w_index_nxt  = w_win_idx;
          w_result_nxt = w_win_res;
          w_state_nxt  = S_HALT;
        end else if (cmd_abort) begin
          w_state_nxt = S_HALT;
        end else if ((r_budget != 32'd0) && (w_cyc_inc == r_budget)) begin
          w_timed_out_nxt = 1'b1;
          w_state_nxt     = S_HALT;
        end
      end
      S_HALT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_found     <= 1'b0;
      r_timed_out <= 1'b0;
      r_clear     <= 1'b0;
      r_start     <= 1'b0;
      r_result    <= '0;
      r_index     <= '0;
      r_cycles    <= '0;
      r_budget    <= '0;
      r_target    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_clear     <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_HALT);
      r_start     <= (w_state_nxt == S_LAUNCH);
      r_found     <= w_found_nxt;
      r_timed_out <= w_timed_out_nxt;
      r_result    <= w_result_nxt;
      r_index     <= w_index_nxt;
      r_cycles    <= w_cycles_nxt;
      r_budget    <= w_budget_nxt;
      r_target    <= w_target_nxt;
    end
  end

  assign busy         = r_busy;
  assign found        = r_found;
  assign timed_out    = r_timed_out;
  assign result       = r_result;
  assign result_index = r_index;
  assign cycles       = r_cycles;
  assign srch_clear   = r_clear;
  assign srch_start   = r_start;
  assign srch_target  = r_target;

endmodule
`default_nettype wire

// File: tb/tb_collision_search_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_collision_search_scheduler: vector table, hand sequences and randomized  |
// | searches checked against an event-ordering model of a search.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_collision_search_scheduler;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start;
  logic [4:0]    cmd_target;
  logic [31:0]   cmd_timeout;
  logic          cmd_abort;
  logic          busy, found, timed_out, srch_clear, srch_start;
  logic [31:0]   result, cycles;
  logic [4:0]    result_index, srch_target;
  logic [N-1:0]  srch_done;
  logic [32*N-1:0] srch_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] res_tbl [N];

  collision_search_scheduler #(.NUM_SEARCHERS(N), .IDX_W(5), .TARGET_W(5)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_target(cmd_target),
    .cmd_timeout(cmd_timeout), .cmd_abort(cmd_abort), .busy(busy), .found(found),
    .timed_out(timed_out), .result(result), .result_index(result_index),
    .cycles(cycles), .srch_clear(srch_clear), .srch_start(srch_start),
    .srch_target(srch_target), .srch_done(srch_done), .srch_result(srch_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tgt;
    logic [31:0] to;
    int          dc;      // RUN cycle carrying done bits, 0 = never
    logic [31:0] mask;
    int          ac;      // RUN cycle carrying abort, 0 = never
    int          bs;      // RUN cycle carrying a stray cmd_start, 0 = never
    logic [31:0] base;    // searcher i reports base + i
    bit          e_found;
    bit          e_to;
    logic [4:0]  e_idx;
    logic [31:0] e_res;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_results();
    for (int i = 0; i < N; i++) srch_result[32*i +: 32] = res_tbl[i];
  endtask

  task automatic run_search(input string nm, input logic [4:0] tgt, input logic [31:0] to,
                            input int dc, input logic [31:0] mask, input int ac, input int bs,
                            input bit junk, input bit e_found, input bit e_to,
                            input logic [4:0] e_idx, input logic [31:0] e_res,
                            input logic [31:0] e_cyc);
    bit ended;
    @(negedge clk);
    cmd_start = 1'b1; cmd_target = tgt; cmd_timeout = to;
    @(negedge clk);
    cmd_start = 1'b0; cmd_target = 5'($urandom); cmd_timeout = $urandom;
    chk({nm, " clear_pulse"}, 32'(srch_clear), 32'd1);
    chk({nm, " no_start_in_clear"}, 32'(srch_start), 32'd0);
    chk({nm, " busy_on"}, 32'(busy), 32'd1);
    chk({nm, " target_latched"}, 32'(srch_target), 32'(tgt));
    srch_done = junk ? '1 : '0;
    @(negedge clk);
    chk({nm, " start_pulse"}, 32'(srch_start), 32'd1);
    chk({nm, " no_clear_in_launch"}, 32'(srch_clear), 32'd0);
    @(negedge clk);
    srch_done = '0;
    chk({nm, " start_one_cycle"}, 32'(srch_start), 32'd0);
    ended = 1'b0;
    for (int c = 1; c <= 100 && !ended; c++) begin
      srch_done = (c == dc) ? mask : '0;
      cmd_abort = (c == ac);
      if (c == bs) begin cmd_start = 1'b1; cmd_target = 5'd9; cmd_timeout = 32'd1; end
      drive_results();
      @(negedge clk);
      srch_done = '0; cmd_abort = 1'b0; cmd_start = 1'b0;
      for (int i = 0; i < N; i++) srch_result[32*i +: 32] = $urandom;
      if (srch_clear) ended = 1'b1;
    end
    if (!ended) begin
      n_checks++; n_fail++;
      $display("FAIL %s halt_wait: got no halt pulse expected one within 100 RUN cycles", nm);
    end else begin
      chk({nm, " cycles"}, cycles, e_cyc);
      chk({nm, " found"}, 32'(found), 32'(e_found));
      chk({nm, " timed_out"}, 32'(timed_out), 32'(e_to));
      chk({nm, " result"}, result, e_res);
      chk({nm, " index"}, 32'(result_index), 32'(e_idx));
      chk({nm, " busy_in_halt"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({nm, " busy_off"}, 32'(busy), 32'd0);
      chk({nm, " clear_one_cycle"}, 32'(srch_clear) | 32'(srch_start), 32'd0);
      chk({nm, " result_held"}, result, e_res);
      chk({nm, " target_kept"}, 32'(srch_target), 32'(tgt));
    end
  endtask

  initial begin
    int kd, ka, kt, endc, idx;
    logic [31:0] mask, to;
    bit exp_f, exp_t;
    int pulses;

    reset = 1'b1; cmd_start = 1'b0; cmd_target = '0; cmd_timeout = '0;
    cmd_abort = 1'b0; srch_done = '0; srch_result = '0;
    for (int i = 0; i < N; i++) res_tbl[i] = '0;
    vecs[0] = '{5'd5, 32'd0, 10, 32'h0000_0008, 0, 0, 32'h60, 1, 0, 5'd3, 32'h63, 32'd10};
    vecs[1] = '{5'd1, 32'd0, 4, 32'h0000_0084, 0, 0, 32'h100, 1, 0, 5'd2, 32'h102, 32'd4};
    vecs[2] = '{5'd2, 32'd4, 0, 32'h0, 0, 0, 32'h0, 0, 1, 5'd0, 32'h0, 32'd4};
    vecs[3] = '{5'd3, 32'd0, 6, 32'h0000_0001, 6, 0, 32'h200, 1, 0, 5'd0, 32'h200, 32'd6};
    vecs[4] = '{5'd4, 32'd0, 0, 32'h0, 6, 0, 32'h0, 0, 0, 5'd0, 32'h0, 32'd6};
    vecs[5] = '{5'd6, 32'd8, 8, 32'h0000_0002, 0, 0, 32'h300, 1, 0, 5'd1, 32'h301, 32'd8};
    vecs[6] = '{5'd7, 32'd1, 0, 32'h0, 0, 0, 32'h0, 0, 1, 5'd0, 32'h0, 32'd1};
    vecs[7] = '{5'd5, 32'd6, 0, 32'h0, 0, 3, 32'h0, 0, 1, 5'd0, 32'h0, 32'd6};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset flags", {29'd0, found, timed_out, srch_clear | srch_start}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset cycles", cycles, 32'd0);
    chk("reset idx_tgt", {22'd0, result_index, srch_target}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) res_tbl[i] = vecs[v].base + 32'(i);
      run_search($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].to, vecs[v].dc, vecs[v].mask,
                 vecs[v].ac, vecs[v].bs, v[0], vecs[v].e_found, vecs[v].e_to,
                 vecs[v].e_idx, vecs[v].e_res, vecs[v].e_cyc);
    end

    // Winner from highest index alone, then status must hold while idle.
    for (int i = 0; i < N; i++) res_tbl[i] = 32'hA0 + 32'(i);
    run_search("idx31", 5'd30, 32'd0, 2, 32'h8000_0000, 0, 0, 1'b0, 1, 0, 5'd31, 32'hBF, 32'd2);
    repeat (3) @(negedge clk);
    chk("hold found", 32'(found), 32'd1);
    chk("hold index", 32'(result_index), 32'd31);

    // Reset during RUN cycle 5.
    @(negedge clk);
    cmd_start = 1'b1; cmd_target = 5'd12; cmd_timeout = 32'd0;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (2) @(negedge clk);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_run busy", 32'(busy), 32'd0);
    chk("rst_run cycles", cycles, 32'd0);
    chk("rst_run found", 32'(found), 32'd0);
    chk("rst_run target", 32'(srch_target), 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (srch_clear || srch_start || busy) pulses++;
      @(negedge clk);
    end
    chk("rst_run quiet", 32'(pulses), 32'd0);

    // Randomized searches scored by which event comes first.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) res_tbl[i] = $urandom;
      kd = $urandom_range(0, 15);
      ka = $urandom_range(0, 15);
      to = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      mask = 32'd1 << $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) mask = mask | $urandom;
      if (kd == 0 && ka == 0 && to == 0) ka = 20;
      endc = 1000;
      if (kd != 0 && kd < endc) endc = kd;
      if (ka != 0 && ka < endc) endc = ka;
      kt = (to == 0) ? 1000 : int'(to);
      if (kt < endc) endc = kt;
      exp_f = (kd == endc);
      exp_t = !exp_f && (ka != endc) && (kt == endc);
      idx = 0;
      if (exp_f) begin
        for (int i = 0; i < N; i++) if (mask[i]) begin idx = i; break; end
      end
      run_search($sformatf("rnd%0d", t), 5'($urandom), to, kd, mask, ka, 0,
                 1'($urandom), exp_f, exp_t, 5'(idx), exp_f ? res_tbl[idx] : 32'd0,
                 32'(endc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/collision_search_scheduler.md
Name: collision_search_scheduler

Overview:
- Sequences one collision search over the parallel searcher array: clears the searchers, launches them, supervises the run with an optional cycle budget and abort, then halts the array.
- Selects the winning result by lowest searcher index and holds status for the processor-facing instruction logic.
- Sits between the custom-instruction decode and the searcher array. It replaces the free-running "any done" reset feedback with an explicit FSM.

Parameters:
NUM_SEARCHERS, 32, number of searcher instances supervised
IDX_W, 5, width of winning-index field (ceil log2 NUM_SEARCHERS, min 1)
TARGET_W, 5, width of collision target passed to searchers

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_start  in  1  one-cycle request to begin a search
cmd_target  in  TARGET_W  target, sampled with cmd_start
cmd_timeout  in  32  RUN-cycle budget, sampled with cmd_start; 0 = unlimited
cmd_abort  in  1  request to stop the current search
busy  out  1  high whenever FSM is not IDLE
found  out  1  last search ended with a collision
timed_out  out  1  last search ended on budget exhaustion
result  out  32  counter value of winning searcher
result_index  out  IDX_W  index of winning searcher
cycles  out  32  RUN cycles spent in the last or current search
srch_clear  out  1  synchronous clear pulse to all searchers
srch_start  out  1  start pulse to all searchers
srch_target  out  TARGET_W  latched target driven to searchers
srch_done  in  NUM_SEARCHERS  per-searcher done flags
srch_result  in  32*NUM_SEARCHERS  flattened results; searcher i at bits [32i+31:32i]

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE.
  - busy, found, timed_out, srch_clear, srch_start = 0.
  - result, result_index, cycles, srch_target = 0.
  - Reset overrides every other input in the same cycle.
- FSM states: IDLE, CLEAR, LAUNCH, RUN, HALT.
- IDLE:
  - cmd_start=1 latches cmd_target into srch_target and cmd_timeout internally, then goes to CLEAR.
  - cmd_abort is ignored.
- CLEAR (1 cycle):
  - srch_clear=1.
  - found, timed_out, cycles, result, result_index cleared to 0.
  - Goes to LAUNCH.
- LAUNCH (1 cycle):
  - srch_start=1.
  - srch_done is ignored (stale).
  - Goes to RUN.
- RUN: each cycle, cycles increments by 1, saturating at 0xFFFFFFFF. Exit priority:
  1. Any srch_done bit set: latch the lowest set index i into result_index and srch_result[i] into result; found<=1; go to HALT.
  2. Else if cmd_abort=1: go to HALT; found and timed_out stay 0.
  3. Else if the budget is non-zero and the incremented cycles value equals the budget: timed_out<=1; go to HALT.
- HALT (1 cycle):
  - srch_clear=1, stopping all searchers.
  - Goes to IDLE.
- Timing:
  - cmd_start sampled at edge 0 → srch_clear high cycle 1 → srch_start high cycle 2 → first RUN cycle 3.
  - srch_done seen in RUN cycle k → cycles=k, found=1 after that edge; srch_clear high in the next cycle; busy=0 one cycle after that.
- busy is a registered output, equal to (state != IDLE).
- srch_clear and srch_start are registered outputs, high for exactly one cycle each, and never high together.
- cmd_start while busy is ignored entirely; latched target and budget are unchanged.
- found, timed_out, result, result_index and cycles hold after a search ends, until the CLEAR of the next accepted cmd_start.
- found and timed_out are mutually exclusive.
- Budget of 1 gives exactly one RUN cycle.
- srch_result is sampled only in the done cycle; later changes do not affect result.
- Reset mid-search: returns to IDLE with all outputs 0. No srch_clear pulse is issued; the searchers receive system reset directly.

Test Plan:
1. cmd_start, target 5, timeout 0; searcher 3 asserts done in RUN cycle 10 with result 0x00000063 → found=1, result=0x63, result_index=3, cycles=10, timed_out=0, one srch_clear pulse after done, busy low 2 cycles after done.
2. Done bits 7 and 2 set in the same cycle, results 0x107 and 0x102 → result_index=2, result=0x102.
3. Timeout 4, no done → timed_out=1, found=0, cycles=4, HALT pulse on the cycle after RUN cycle 4.
4. RUN cycle 6 with cmd_abort=1 and done bit 0 set → found=1, result_index=0. Separately, abort alone at cycle 6 → found=0, timed_out=0, cycles=6.
5. Timeout 8 with done bit 1 set in RUN cycle 8 → found=1, timed_out=0, cycles=8.
6. cmd_start with target 9 during RUN → ignored, srch_target unchanged. Reset asserted in RUN cycle 5 → next cycle busy=0, cycles=0, found=0; no srch_start or srch_clear pulses until a new cmd_start.
